uc_multiciclo: RTL and testbench
================================

// Module: uc_multiciclo
// PURPOSE
//   Multicycle RV32I control unit (Moore FSM). Sequences the shared datapath:
//   one memory, one ALU, and the PC/IR/ALUOut/Data registers.
//   Executes each instruction over 3-5 states and stalls memory states on mem_ready.
//   Supports lw, sw, R-type (add/sub/and/or/slt), I-type ALU, beq and jal.
// PARAMETERS
//   none (ALU/imm encodings fixed, identical to single-cycle UC)
// PORTS
//   clk         in   1  single clock, rising edge
//   rst_n       in   1  asynchronous, active-low reset
//   op          in   7  instr[6:0], from IR
//   func3       in   3  instr[14:12]
//   func7       in   1  instr[30]
//   zero        in   1  ALU zero flag
//   mem_ready   in   1  memory handshake: access completes this cycle
//   pcWrite     out  1  PC load enable
//   adrSrc      out  1  mem address select: 0=PC, 1=ALUOut
//   memWrite    out  1  memory write strobe
//   irWrite     out  1  IR/oldPC load enable
//   regWrite    out  1  register file write enable
//   resultSrc   out  2  00=ALUOut, 01=Data, 10=ALU result
//   aluSrcA     out  2  00=PC, 01=oldPC, 10=rs1
//   aluSrcB     out  2  00=rs2, 01=imm, 10=const 4
//   aluControl  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
//   immSrc      out  2  00 I, 01 S, 10 B, 11 J (decoded from op)
//   instr_done  out  1  pulse in the last cycle of each instruction
//   illegal     out  1  pulse in DECODE when op is unsupported
//   state       out  4  current state, for debug
// BEHAVIOUR
//   - Reset: while rst_n=0, state=FETCH(0). All enables (pcWrite, memWrite,
//     irWrite, regWrite, instr_done, illegal) are forced 0.
//     Reset mid-instruction aborts it; no partial write strobe is emitted.
//   - State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4,
//     MEMWRITE=5, EXECR=6, ALUWB=7, EXECI=8, JAL=9, BEQ=10. Codes 11-15 -> FETCH.
//   - Transitions:
//       FETCH -> DECODE on mem_ready, else stay.
//       DECODE -> MEMADR (lw/sw), EXECR (0110011), EXECI (0010011),
//                 JAL (1101111), BEQ (1100011); any other op -> FETCH, illegal=1.
//       MEMADR -> MEMREAD (lw) | MEMWRITE (sw).
//       MEMREAD -> MEMWB on mem_ready, else stay.   MEMWB -> FETCH.
//       MEMWRITE -> FETCH on mem_ready, else stay.
//       EXECR, EXECI, JAL -> ALUWB.   ALUWB -> FETCH.   BEQ -> FETCH.
//   - Per-state outputs; unlisted outputs are 0 (ALU op=add):
//       FETCH:    adrSrc=0, aluSrcA=00, aluSrcB=10, resultSrc=10.
//                 irWrite=pcWrite=mem_ready (PC<=PC+4 once per fetch).
//       DECODE:   aluSrcA=01, aluSrcB=01 (branch/jump target into ALUOut).
//       MEMADR:   aluSrcA=10, aluSrcB=01.
//       MEMREAD:  adrSrc=1.
//       MEMWB:    resultSrc=01, regWrite=1.
//       MEMWRITE: adrSrc=1, memWrite=1 held until mem_ready.
//       EXECR:    aluSrcA=10, aluSrcB=00, aluControl from func.
//       EXECI:    aluSrcA=10, aluSrcB=01, aluControl from func.
//       ALUWB:    resultSrc=00, regWrite=1.
//       JAL:      aluSrcA=01, aluSrcB=10, resultSrc=00, pcWrite=1.
//       BEQ:      aluSrcA=10, aluSrcB=00, aluControl=001, resultSrc=00,
//                 pcWrite=zero.
//   - Function decode: func3=000 -> sub if op[5]&func7, else add (addi ignores func7).
//     010 -> slt, 110 -> or, 111 -> and; other func3 -> add.
//   - Latency with mem_ready=1: lw 5, sw/R/I/jal 4, beq 3 cycles.
//     Each mem_ready=0 cycle in FETCH/MEMREAD/MEMWRITE adds one cycle.
//   - instr_done=1 in MEMWB, MEMWRITE&mem_ready, ALUWB, BEQ, and in DECODE on illegal.
// TESTING
//   1. Reset pulse mid-MEMWRITE -> memWrite=0 immediately, state=0, then FETCH resumes.
//   2. lw (0000011), mem_ready=1 -> states 0,1,2,3,4; regWrite=1 only in 4 with resultSrc=01.
//   3. sw, mem_ready low 3 cycles in MEMWRITE -> memWrite held 4 cycles; 1 done pulse.
//   4. R-type func3=000 func7=1 -> aluControl=001 in EXECR. addi with func7=1 -> 000.
//   5. beq zero=1 -> pcWrite=1 in BEQ. zero=0 -> pcWrite=0. Both end after 3 cycles.
//   6. op=0000000 -> illegal=1 in DECODE, no writes, next state FETCH.

Source files
------------

// File: rtl/uc_multiciclo.sv
// ---------------------------------------------------------------------------
// uc_multiciclo
//   Control unit for a multicycle RV32I datapath (one shared memory, one ALU,
//   PC / IR / ALUOut / Data registers). Moore-style FSM: every control output
//   is decoded from the current state. The only exceptions are the handshake
//   and branch qualifiers (mem_ready, zero), which gate a few strobes so that a
//   stalled access or an untaken branch never produces a write.
//   Supported instructions: lw, sw, R-type, I-type ALU, beq, jal.
// ---------------------------------------------------------------------------
module uc_multiciclo (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic [2:0] func3,
    input  logic       func7,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pcWrite,
    output logic       adrSrc,
    output logic       memWrite,
    output logic       irWrite,
    output logic       regWrite,
    output logic [1:0] resultSrc,
    output logic [1:0] aluSrcA,
    output logic [1:0] aluSrcB,
    output logic [2:0] aluControl,
    output logic [1:0] immSrc,
    output logic       instr_done,
    output logic       illegal,
    output logic [3:0] state
);

    // State codes are visible on the debug port, so they are fixed values.
    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXECR    = 4'd6;
    localparam logic [3:0] S_ALUWB    = 4'd7;
    localparam logic [3:0] S_EXECI    = 4'd8;
    localparam logic [3:0] S_JAL      = 4'd9;
    localparam logic [3:0] S_BEQ      = 4'd10;

    // Opcodes understood by this control unit.
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    // ALU operation encodings shared with the single-cycle datapath.
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    // Mux select encodings.
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCB_RS2   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    // Immediate format encodings.
    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    logic [3:0] state_q;
    logic [3:0] state_d;
    logic       op_supported;

    // Raw enables before the reset gate.
    logic pc_we;
    logic mem_we;
    logic ir_we;
    logic reg_we;
    logic done_raw;
    logic illegal_raw;

    // func3/func7 to ALU operation. Subtraction is only meaningful for R-type
    // (op[5]=1); addi with instr[30] set is still an add.
    function automatic logic [2:0] alu_decode(input logic       op5,
                                              input logic [2:0] f3,
                                              input logic       f7);
        logic [2:0] ctl;
        case (f3)
            3'b000:  ctl = (op5 && f7) ? ALU_SUB : ALU_ADD;
            3'b010:  ctl = ALU_SLT;
            3'b110:  ctl = ALU_OR;
            3'b111:  ctl = ALU_AND;
            default: ctl = ALU_ADD;
        endcase
        return ctl;
    endfunction

    // Opcode is one the sequencer knows how to execute.
    always_comb begin
        op_supported = (op == OP_LW) || (op == OP_SW) || (op == OP_R) ||
                       (op == OP_I)  || (op == OP_JAL) || (op == OP_BEQ);
    end

    // State register; reset lands in FETCH and aborts any instruction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; memory states hold until the access completes.
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:    state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECR;
                    OP_I:         state_d = S_EXECI;
                    OP_JAL:       state_d = S_JAL;
                    OP_BEQ:       state_d = S_BEQ;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR:   state_d = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  state_d = mem_ready ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: state_d = mem_ready ? S_FETCH : S_MEMWRITE;
            S_EXECR:    state_d = S_ALUWB;
            S_EXECI:    state_d = S_ALUWB;
            S_JAL:      state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BEQ:      state_d = S_FETCH;
            default:    state_d = S_FETCH;
        endcase
    end

    // Immediate format follows the opcode regardless of state.
    always_comb begin
        case (op)
            OP_SW:   immSrc = IMM_S;
            OP_BEQ:  immSrc = IMM_B;
            OP_JAL:  immSrc = IMM_J;
            default: immSrc = IMM_I;
        endcase
    end

    // Per-state datapath selects and raw enables; anything not set stays 0.
    always_comb begin
        adrSrc      = 1'b0;
        resultSrc   = RES_ALUOUT;
        aluSrcA     = SRCA_PC;
        aluSrcB     = SRCB_RS2;
        aluControl  = ALU_ADD;
        pc_we       = 1'b0;
        mem_we      = 1'b0;
        ir_we       = 1'b0;
        reg_we      = 1'b0;
        done_raw    = 1'b0;
        illegal_raw = 1'b0;
        case (state_q)
            S_FETCH: begin
                // PC+4 is written back only when the instruction word arrives,
                // so a stalled fetch advances the PC exactly once.
                aluSrcA   = SRCA_PC;
                aluSrcB   = SRCB_FOUR;
                resultSrc = RES_ALU;
                ir_we     = mem_ready;
                pc_we     = mem_ready;
            end
            S_DECODE: begin
                // Speculatively compute oldPC+imm for beq/jal into ALUOut.
                aluSrcA     = SRCA_OLDPC;
                aluSrcB     = SRCB_IMM;
                illegal_raw = !op_supported;
                done_raw    = !op_supported;
            end
            S_MEMADR: begin
                aluSrcA = SRCA_RS1;
                aluSrcB = SRCB_IMM;
            end
            S_MEMREAD: begin
                adrSrc = 1'b1;
            end
            S_MEMWB: begin
                resultSrc = RES_DATA;
                reg_we    = 1'b1;
                done_raw  = 1'b1;
            end
            S_MEMWRITE: begin
                adrSrc   = 1'b1;
                mem_we   = 1'b1;
                done_raw = mem_ready;
            end
            S_EXECR: begin
                aluSrcA    = SRCA_RS1;
                aluSrcB    = SRCB_RS2;
                aluControl = alu_decode(op[5], func3, func7);
            end
            S_EXECI: begin
                aluSrcA    = SRCA_RS1;
                aluSrcB    = SRCB_IMM;
                aluControl = alu_decode(op[5], func3, func7);
            end
            S_ALUWB: begin
                resultSrc = RES_ALUOUT;
                reg_we    = 1'b1;
                done_raw  = 1'b1;
            end
            S_JAL: begin
                // ALU forms the link value oldPC+4 while PC takes the target
                // already sitting in ALUOut.
                aluSrcA   = SRCA_OLDPC;
                aluSrcB   = SRCB_FOUR;
                resultSrc = RES_ALUOUT;
                pc_we     = 1'b1;
            end
            S_BEQ: begin
                aluSrcA    = SRCA_RS1;
                aluSrcB    = SRCB_RS2;
                aluControl = ALU_SUB;
                resultSrc  = RES_ALUOUT;
                pc_we      = zero;
                done_raw   = 1'b1;
            end
            default: begin
                // Unused codes produce no activity and fall back to FETCH.
            end
        endcase
    end

    // Write strobes are suppressed while reset is asserted so a reset in the
    // middle of an access never leaks a partial write.
    always_comb begin
        pcWrite    = pc_we       & rst_n;
        memWrite   = mem_we      & rst_n;
        irWrite    = ir_we       & rst_n;
        regWrite   = reg_we      & rst_n;
        instr_done = done_raw    & rst_n;
        illegal    = illegal_raw & rst_n;
        state      = state_q;
    end

endmodule

// File: tb/tb_uc_multiciclo.sv
// ---------------------------------------------------------------------------
// tb_uc_multiciclo
//   Directed bench for the multicycle control unit. Inputs change on the
//   falling edge; outputs are sampled 1 ns after it.
// ---------------------------------------------------------------------------
module tb_uc_multiciclo;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    logic       clk;
    logic       rst_n;
    logic [6:0] op;
    logic [2:0] func3;
    logic       func7;
    logic       zero;
    logic       mem_ready;
    logic       pcWrite;
    logic       adrSrc;
    logic       memWrite;
    logic       irWrite;
    logic       regWrite;
    logic [1:0] resultSrc;
    logic [1:0] aluSrcA;
    logic [1:0] aluSrcB;
    logic [2:0] aluControl;
    logic [1:0] immSrc;
    logic       instr_done;
    logic       illegal;
    logic [3:0] state;

    int checks;
    int failures;

    uc_multiciclo dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .op         (op),
        .func3      (func3),
        .func7      (func7),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .pcWrite    (pcWrite),
        .adrSrc     (adrSrc),
        .memWrite   (memWrite),
        .irWrite    (irWrite),
        .regWrite   (regWrite),
        .resultSrc  (resultSrc),
        .aluSrcA    (aluSrcA),
        .aluSrcB    (aluSrcB),
        .aluControl (aluControl),
        .immSrc     (immSrc),
        .instr_done (instr_done),
        .illegal    (illegal),
        .state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reset held: FETCH, all strobes forced low even with mem_ready high.
    task automatic test_reset;
        rst_n = 1'b0; mem_ready = 1'b1; op = OP_LW;
        #1;
        checks++;
        if (state !== 4'd0) begin failures++; $display("FAIL rst_state got=%0d exp=0", state); end
        checks++;
        if ({irWrite, pcWrite, memWrite, regWrite, instr_done, illegal} !== 6'b0) begin
            failures++;
            $display("FAIL rst_enables got=%b exp=000000",
                     {irWrite, pcWrite, memWrite, regWrite, instr_done, illegal});
        end
        @(negedge clk); @(negedge clk); #1;
        checks++;
        if (state !== 4'd0 || irWrite !== 1'b0) begin
            failures++; $display("FAIL rst_hold got state=%0d irWrite=%b exp 0/0", state, irWrite);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (irWrite !== 1'b1 || pcWrite !== 1'b1) begin
            failures++; $display("FAIL rst_release_fetch got ir=%b pc=%b exp 1/1", irWrite, pcWrite);
        end
        mem_ready = 1'b0;
        #1;
        checks++;
        if (irWrite !== 1'b0 || pcWrite !== 1'b0) begin
            failures++; $display("FAIL fetch_stall got ir=%b pc=%b exp 0/0", irWrite, pcWrite);
        end
    endtask

    // lw: 0,1,2,3,4 then FETCH; register write only in MEMWB from Data.
    task automatic test_lw;
        logic [3:0] exp_st [5];
        exp_st = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
        op = OP_LW; mem_ready = 1'b1; zero = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            checks++;
            if (state !== exp_st[i]) begin
                failures++; $display("FAIL lw_state[%0d] got=%0d exp=%0d", i, state, exp_st[i]);
            end
            checks++;
            if (regWrite !== (i == 4) || instr_done !== (i == 4)) begin
                failures++; $display("FAIL lw_wb[%0d] got reg=%b done=%b exp %b", i, regWrite, instr_done, (i == 4));
            end
        end
        checks++;
        if (resultSrc !== 2'b01) begin failures++; $display("FAIL lw_resultSrc got=%b exp=01", resultSrc); end
        @(negedge clk); #1;
        checks++;
        if (state !== 4'd0) begin failures++; $display("FAIL lw_end got=%0d exp=0", state); end
    endtask

    // Spot-check the select values of FETCH/MEMADR/MEMREAD during one lw.
    task automatic test_lw_selects;
        op = OP_LW; mem_ready = 1'b1;
        #1;
        checks++;
        if ({adrSrc, aluSrcA, aluSrcB, resultSrc} !== 7'b0_00_10_10) begin
            failures++; $display("FAIL fetch_sel got=%b exp=0001010", {adrSrc, aluSrcA, aluSrcB, resultSrc});
        end
        @(negedge clk); #1;
        checks++;
        if ({aluSrcA, aluSrcB, immSrc} !== 6'b01_01_00) begin
            failures++; $display("FAIL decode_sel got=%b exp=010100", {aluSrcA, aluSrcB, immSrc});
        end
        @(negedge clk); #1;
        checks++;
        if ({aluSrcA, aluSrcB} !== 4'b10_01) begin
            failures++; $display("FAIL memadr_sel got=%b exp=1001", {aluSrcA, aluSrcB});
        end
        @(negedge clk); #1;
        checks++;
        if (adrSrc !== 1'b1 || memWrite !== 1'b0) begin
            failures++; $display("FAIL memread_sel got adr=%b mw=%b exp 1/0", adrSrc, memWrite);
        end
        @(negedge clk); @(negedge clk); #1;
        checks++;
        if (state !== 4'd0) begin failures++; $display("FAIL lwsel_end got=%0d exp=0", state); end
    endtask

    // sw with three stalled cycles in MEMWRITE: strobe held 4 cycles, 1 done.
    task automatic test_sw_stall;
        int mw_cnt;
        int done_cnt;
        mw_cnt = 0; done_cnt = 0;
        op = OP_SW; mem_ready = 1'b1;
        #1;
        @(negedge clk); #1;
        checks++;
        if (state !== 4'd1 || immSrc !== 2'b01) begin
            failures++; $display("FAIL sw_decode got st=%0d imm=%b exp 1/01", state, immSrc);
        end
        @(negedge clk); #1;
        checks++;
        if (state !== 4'd2) begin failures++; $display("FAIL sw_memadr got=%0d exp=2", state); end
        mem_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k == 3) mem_ready = 1'b1;
            #1;
            if (memWrite === 1'b1) mw_cnt++;
            if (instr_done === 1'b1) done_cnt++;
            checks++;
            if (state !== 4'd5 || adrSrc !== 1'b1) begin
                failures++; $display("FAIL sw_memwrite[%0d] got st=%0d adr=%b exp 5/1", k, state, adrSrc);
            end
        end
        @(negedge clk); #1;
        checks++;
        if (state !== 4'd0) begin failures++; $display("FAIL sw_end got=%0d exp=0", state); end
        checks++;
        if (mw_cnt != 4 || done_cnt != 1) begin
            failures++; $display("FAIL sw_counts got mw=%0d done=%0d exp 4/1", mw_cnt, done_cnt);
        end
    endtask

    // R-type and I-type ALU decode, including func7 ignored by addi.
    task automatic test_alu_ops;
        logic [6:0] t_op [7];
        logic [2:0] t_f3 [7];
        logic       t_f7 [7];
        logic [3:0] t_st [7];
        logic [2:0] t_alu [7];
        logic [1:0] t_srcb [7];
        t_op   = '{OP_R,   OP_I,   OP_R,   OP_R,   OP_R,   OP_I,   OP_I};
        t_f3   = '{3'b000, 3'b000, 3'b000, 3'b010, 3'b110, 3'b111, 3'b001};
        t_f7   = '{1'b1,   1'b1,   1'b0,   1'b0,   1'b0,   1'b0,   1'b0};
        t_st   = '{4'd6,   4'd8,   4'd6,   4'd6,   4'd6,   4'd8,   4'd8};
        t_alu  = '{3'b001, 3'b000, 3'b000, 3'b101, 3'b011, 3'b010, 3'b000};
        t_srcb = '{2'b00,  2'b01,  2'b00,  2'b00,  2'b00,  2'b01,  2'b01};
        mem_ready = 1'b1;
        for (int t = 0; t < 7; t++) begin
            op = t_op[t]; func3 = t_f3[t]; func7 = t_f7[t];
            #1;
            @(negedge clk); @(negedge clk); #1;
            checks++;
            if (state !== t_st[t] || aluControl !== t_alu[t]) begin
                failures++;
                $display("FAIL alu_exec[%0d] got st=%0d ctl=%b exp %0d/%b", t, state, aluControl, t_st[t], t_alu[t]);
            end
            checks++;
            if (aluSrcA !== 2'b10 || aluSrcB !== t_srcb[t] || regWrite !== 1'b0) begin
                failures++;
                $display("FAIL alu_src[%0d] got a=%b b=%b rw=%b exp 10/%b/0", t, aluSrcA, aluSrcB, regWrite, t_srcb[t]);
            end
            @(negedge clk); #1;
            checks++;
            if (state !== 4'd7 || regWrite !== 1'b1 || instr_done !== 1'b1 || resultSrc !== 2'b00) begin
                failures++;
                $display("FAIL alu_wb[%0d] got st=%0d rw=%b done=%b res=%b exp 7/1/1/00", t, state, regWrite, instr_done, resultSrc);
            end
            @(negedge clk);
        end
        #1;
        checks++;
        if (state !== 4'd0) begin failures++; $display("FAIL alu_end got=%0d exp=0", state); end
        func3 = 3'b000; func7 = 1'b0;
    endtask

    // beq taken / not taken: 3 cycles each, pcWrite follows zero.
    task automatic test_beq;
        for (int z = 1; z >= 0; z--) begin
            op = OP_BEQ; mem_ready = 1'b1; zero = z[0];
            #1;
            @(negedge clk); #1;
            checks++;
            if (immSrc !== 2'b10) begin failures++; $display("FAIL beq_imm got=%b exp=10", immSrc); end
            @(negedge clk); #1;
            checks++;
            if (state !== 4'd10 || pcWrite !== z[0] || aluControl !== 3'b001 || instr_done !== 1'b1) begin
                failures++;
                $display("FAIL beq_z%0d got st=%0d pcw=%b ctl=%b done=%b exp 10/%b/001/1", z, state, pcWrite, aluControl, instr_done, z[0]);
            end
            @(negedge clk); #1;
            checks++;
            if (state !== 4'd0) begin failures++; $display("FAIL beq_end_z%0d got=%0d exp=0", z, state); end
        end
        zero = 1'b0;
    endtask

    // jal: JAL state writes PC and forms the link, then ALUWB.
    task automatic test_jal;
        op = OP_JAL; mem_ready = 1'b1;
        #1;
        @(negedge clk); #1;
        checks++;
        if (immSrc !== 2'b11) begin failures++; $display("FAIL jal_imm got=%b exp=11", immSrc); end
        @(negedge clk); #1;
        checks++;
        if (state !== 4'd9 || pcWrite !== 1'b1 || aluSrcA !== 2'b01 || aluSrcB !== 2'b10) begin
            failures++; $display("FAIL jal_state got st=%0d pcw=%b a=%b b=%b exp 9/1/01/10", state, pcWrite, aluSrcA, aluSrcB);
        end
        @(negedge clk); #1;
        checks++;
        if (state !== 4'd7 || regWrite !== 1'b1) begin
            failures++; $display("FAIL jal_wb got st=%0d rw=%b exp 7/1", state, regWrite);
        end
        @(negedge clk); #1;
        checks++;
        if (state !== 4'd0) begin failures++; $display("FAIL jal_end got=%0d exp=0", state); end
    endtask

    // Unsupported opcode: illegal + done in DECODE, no writes, back to FETCH.
    task automatic test_illegal;
        op = 7'b0000000; mem_ready = 1'b1;
        #1;
        @(negedge clk); #1;
        checks++;
        if (state !== 4'd1 || illegal !== 1'b1 || instr_done !== 1'b1) begin
            failures++; $display("FAIL illegal_flag got st=%0d ill=%b done=%b exp 1/1/1", state, illegal, instr_done);
        end
        checks++;
        if ({pcWrite, memWrite, regWrite, irWrite} !== 4'b0) begin
            failures++; $display("FAIL illegal_writes got=%b exp=0000", {pcWrite, memWrite, regWrite, irWrite});
        end
        @(negedge clk); #1;
        checks++;
        if (state !== 4'd0 || illegal !== 1'b0) begin
            failures++; $display("FAIL illegal_next got st=%0d ill=%b exp 0/0", state, illegal);
        end
    endtask

    // Reset asserted while MEMWRITE is stalled: strobe drops immediately.
    task automatic test_reset_mid_write;
        op = OP_SW; mem_ready = 1'b1;
        #1;
        @(negedge clk); @(negedge clk);
        mem_ready = 1'b0;
        @(negedge clk); #1;
        checks++;
        if (state !== 4'd5 || memWrite !== 1'b1) begin
            failures++; $display("FAIL rmw_pre got st=%0d mw=%b exp 5/1", state, memWrite);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (state !== 4'd0 || memWrite !== 1'b0 || instr_done !== 1'b0) begin
            failures++; $display("FAIL rmw_abort got st=%0d mw=%b done=%b exp 0/0/0", state, memWrite, instr_done);
        end
        @(negedge clk);
        rst_n = 1'b1; mem_ready = 1'b1;
        #1;
        checks++;
        if (state !== 4'd0 || irWrite !== 1'b1) begin
            failures++; $display("FAIL rmw_resume got st=%0d ir=%b exp 0/1", state, irWrite);
        end
        @(negedge clk);
        op = 7'b0000000;
        #1;
        checks++;
        if (state !== 4'd1) begin failures++; $display("FAIL rmw_decode got=%0d exp=1", state); end
        @(negedge clk); #1;
    endtask

    initial begin
        checks = 0; failures = 0;
        rst_n = 1'b0; op = 7'b0; func3 = 3'b0; func7 = 1'b0; zero = 1'b0; mem_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_lw();
        test_lw_selects();
        test_sw_stall();
        test_alu_ops();
        test_beq();
        test_jal();
        test_illegal();
        test_reset_mid_write();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
